// File: rtl/clk_div_prog_pkg.sv
// Shared constants, state encoding and half-period helper for the programmable divider.
package clk_div_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIV   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ceil(n/2): number of high cycles in a period of n cycles
  function automatic logic [31:0] half_period(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable divider.
interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             en;
  logic [WIDTH-1:0] div;
  logic             load;
  logic             q;
  logic             tick;
  logic [WIDTH-1:0] div_act;

  modport master (output en, div, load, input q, tick, div_act);
  modport slave  (input en, div, load, output q, tick, div_act);

endinterface

// File: rtl/clk_div_prog_ctr.sv
// Wrap-at-N-1 period counter with synchronous clear; exposes next value and wrap flag.
module div_ctr
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;

  // wrap detection and next count value
  always_comb begin
    wrap     = (cnt == n - WIDTH'(1));
    cnt_next = wrap ? '0 : cnt + WIDTH'(1);
  end

  // count register: clear restarts a period, advance steps within it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable divider: q high for ceil(N/2) of every N enabled cycles, tick at period
// start; divisor changes are staged and applied only at period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_prog_if.slave bus
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] div_act, div_act_nx;
  logic [WIDTH-1:0] div_pend, div_pend_nx;
  logic             pend, pend_nx;
  logic             q_r, q_nx;
  logic             tick_r, tick_nx;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] half_cur;
  logic             wrap;
  logic             bnd;
  logic             ctr_clr, ctr_adv;

  assign ctr_clr = bus.en && (state == IDLE);
  assign ctr_adv = bus.en && (state == RUN);

  div_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .adv      (ctr_adv),
    .n        (div_act),
    .cnt_next (cnt_next),
    .wrap     (wrap)
  );

  // next state: divisor staging, boundary handling, q/tick generation
  always_comb begin
    state_nx    = state;
    div_act_nx  = div_act;
    div_pend_nx = div_pend;
    pend_nx     = pend;
    q_nx        = q_r;
    tick_nx     = 1'b0;
    half_cur    = WIDTH'(half_period(32'(div_act)));
    bnd         = bus.en && ((state == IDLE) || wrap);

    if (bus.load) begin
      div_pend_nx = bus.div;
      pend_nx     = 1'b1;
    end

    if (bnd) begin
      // a load on the boundary edge bypasses staging and governs the new period
      if (bus.load) begin
        div_act_nx = bus.div;
      end else if (pend) begin
        div_act_nx = div_pend;
      end
      pend_nx = 1'b0;
      if (div_act_nx == '0) begin
        state_nx = IDLE;
        q_nx     = 1'b0;
      end else begin
        state_nx = RUN;
        q_nx     = 1'b1;
        tick_nx  = 1'b1;
      end
    end else if (bus.en) begin
      q_nx = (cnt_next < half_cur);
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_act  <= WIDTH'(DEFAULT_DIV);
      div_pend <= '0;
      pend     <= 1'b0;
      q_r      <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      div_act  <= div_act_nx;
      div_pend <= div_pend_nx;
      pend     <= pend_nx;
      q_r      <= q_nx;
      tick_r   <= tick_nx;
    end
  end

  assign bus.q       = q_r;
  assign bus.tick    = tick_r;
  assign bus.div_act = div_act;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic against a period-level model.
module tb_clk_div_prog;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  // reference model: position within the current period and the divisor in force
  int   m_run, m_n, m_k, m_pend, m_pval;
  logic m_q, m_tick;

  clk_div_prog_if #(.WIDTH(8)) bus ();

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_n = 4; m_k = 0; m_pend = 0; m_pval = 0;
    m_q = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input int d);
    if (!e) begin
      m_tick = 1'b0;
      if (l) begin m_pend = 1; m_pval = d; end
    end else if (!m_run || m_k == m_n - 1) begin
      if (l) m_n = d;
      else if (m_pend) m_n = m_pval;
      m_pend = 0;
      m_k = 0;
      if (m_n == 0) begin
        m_run = 0; m_q = 1'b0; m_tick = 1'b0;
      end else begin
        m_run = 1; m_q = 1'b1; m_tick = 1'b1;
      end
    end else begin
      if (l) begin m_pend = 1; m_pval = d; end
      m_k++;
      m_q = (m_k < (m_n + 1) / 2);
      m_tick = 1'b0;
    end
  endtask

  // one clock: drive, let the edge happen, update model, compare #1 later
  task automatic cyc(input logic e, input logic l, input int d);
    bus.en = e; bus.load = l; bus.div = 8'(d);
    @(posedge clk);
    model_edge(e, l, d);
    #1;
    chk("q", 32'(bus.q), 32'(m_q));
    chk("tick", 32'(bus.tick), 32'(m_tick));
    chk("div_act", 32'(bus.div_act), 32'(m_n));
    bus.load = 1'b0;
  endtask

  // reset asserted between edges; outputs must clear without a clock
  task automatic rst_pulse();
    #2 rst = 1'b0;
    #1;
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_div_act", 32'(bus.div_act), 32'd4);
    chk("rst_cnt", 32'(dut.u_ctr.cnt), 32'd0);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic run_to_period_start();
    for (int i = 0; i < 300; i++) begin
      if (m_run == 1 && m_k == 0) return;
      cyc(1'b1, 1'b0, 0);
    end
    chk("period_start_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b1; bus.load = 1'b0; bus.div = '0;
    model_reset();
    #12;
    chk("init_q", 32'(bus.q), 32'd0);
    chk("init_tick", 32'(bus.tick), 32'd0);
    chk("init_div_act", 32'(bus.div_act), 32'd4);
    #8 rst = 1'b1;

    // default N=4: first tick on the first edge after release, then 1,1,0,0
    cyc(1'b1, 1'b0, 0);
    chk("first_tick", 32'(bus.tick), 32'd1);
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 0);

    // load 5 from IDLE: 3 high / 2 low
    rst_pulse();
    cyc(1'b1, 1'b1, 5);
    chk("div5_applied", 32'(bus.div_act), 32'd5);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 0);

    // back to 4, then stage 6 while cnt=1
    cyc(1'b1, 1'b1, 4);
    run_to_period_start();
    cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 6);
    chk("div6_staged", 32'(bus.div_act), 32'd4);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 0);

    // en low for 3 cycles at cnt=0 with N=4
    cyc(1'b1, 1'b1, 4);
    run_to_period_start();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 0);
      chk("hold_q", 32'(bus.q), 32'd1);
    end
    cyc(1'b1, 1'b0, 0);
    chk("resume_q_high", 32'(bus.q), 32'd1);
    cyc(1'b1, 1'b0, 0);
    chk("resume_q_low", 32'(bus.q), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 0);

    // N=0 parks the divider, N=1 gives q=1 and tick every cycle
    cyc(1'b1, 1'b1, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 0);
    chk("n0_q", 32'(bus.q), 32'd0);
    cyc(1'b1, 1'b1, 1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0);
    chk("n1_tick", 32'(bus.tick), 32'd1);

    // random enable/load traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 9) == 0),
          ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 9)));
    end

    // reset mid-period, restart on the first enabled edge
    cyc(1'b1, 1'b1, 7);
    run_to_period_start();
    cyc(1'b1, 1'b0, 0);
    rst_pulse();
    cyc(1'b1, 1'b0, 0);
    chk("restart_tick", 32'(bus.tick), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable clock-enable/clock divider, the parametrised successor to the fixed divide-by-4 block. Produces a divided output `q` of run-time-selectable ratio N (0..2^WIDTH-1), near-50% duty for odd N, exact 50% for even N, plus a one-cycle period-start strobe. Divisor changes are staged and applied only at a period boundary, so `q` never glitches. Sits beside the divide-by-4 block and serves as the general divider for downstream timing logic.

## Interface
- `WIDTH`, 8: width of divisor and internal counter.
- `DEFAULT_DIV`, 4: active divisor after reset (must be < 2^WIDTH).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `en` input 1: count enable; low freezes all state.
- `div` input WIDTH: new divisor value, sampled when `load`=1.
- `load` input 1: single-cycle request to stage `div`.
- `q` output 1: divided output, registered.
- `tick` output 1: one-cycle pulse on the edge that starts each output period, registered.
- `div_act` output WIDTH: divisor currently in effect.

## Operation
- Registers: `cnt` (WIDTH), `run` flag, `div_act`, `div_pend`, `pend` flag, `q`, `tick`.
- Reset (`rst`=0): `cnt`=0, `run`=0, `q`=0, `tick`=0, `div_act`=DEFAULT_DIV, `pend`=0. Outputs go to these values immediately, without waiting for a clock edge.
- H = ceil(N/2), with N = `div_act`. `q` is high for H cycles and low for N-H cycles.
- States: IDLE (`run`=0) and RUN (`run`=1).
- IDLE, enabled edge, N>=1: `cnt`<=0, `q`<=1, `tick`<=1, `run`<=1.
- RUN, enabled edge: `cnt_next` = (`cnt`==N-1) ? 0 : `cnt`+1. `q`<=(`cnt_next`<H). `tick`<=(`cnt_next`==0).
- `en`=0: `cnt`, `q`, and `run` hold. `tick`<=0. A `load` is still captured.
- `load`=1: `div_pend`<=`div`, `pend`<=1. With several loads before a boundary, the last one wins.
- Boundary is an enabled edge with `cnt`==N-1, or any enabled edge in IDLE.
  - At a boundary with `pend`=1, `div_act`<=`div_pend` and `pend`<=0.
  - The new N governs the period that starts on that edge.
  - If `load` coincides with a boundary, the value on `div` that cycle is applied directly.
- N=0: `run`<=0, `q`<=0, `tick`<=0, and the block stays in IDLE until a nonzero divisor is applied.
- N=1: `q` stays at 1 and `tick` pulses every enabled cycle.

## Timing
- The first `q` rise and `tick` occur on the first enabled edge after reset release, which is 1-cycle latency.
- Output period = N enabled cycles. `tick` is high for exactly one cycle per period and coincides with the `q` rising edge (N>=2).
- Load-to-effect latency: at most N cycles; it takes effect at the next boundary.
- `q` is driven only by a flop, so it is glitch-free.
- Reset asserted mid-period aborts the period. After release, restart follows the IDLE rule.

## Structure
- Package `clk_div_pkg` holds:
  - the default `WIDTH` and `DEFAULT_DIV` constants;
  - the half-period function ceil(N/2);
  - the state encoding constants IDLE/RUN.
- One sub-module is natural: `div_ctr`, a loadable wrap-at-N-1 counter that provides `cnt_next` and the wrap flag. Top level keeps staging, `q`/`tick` generation, and state.

## Test plan
- Reset, 10 ns clock, `rst`=0 for 20 ns, `en`=1, no load:
  - `div_act`=4.
  - `q` is 1,1,0,0 repeating with a 40 ns period.
  - `tick` occurs every 4th cycle, and the first `tick` is on the first edge after release.
- Load `div`=5 from IDLE: `q` is high 3 cycles, low 2 cycles; `tick` every 5 cycles; `div_act`=5.
- N=4 running; `load` `div`=6 at `cnt`=1:
  - The current period completes in 4 cycles.
  - The next period is 3 high, 3 low.
  - `div_act` changes on the `tick` edge.
- Drop `en` for 3 cycles at `cnt`=0 (N=4): `q` holds 1 and `tick` stays 0. After re-enable, `q` stays high 1 more cycle and then falls.
- Load `div`=0: after the boundary, `q`=0 and `tick`=0 permanently. Then load 1: `q`=1 and `tick`=1 every cycle.
- Assert `rst` mid-period between edges: `q`, `tick`, and `cnt` go to 0 immediately, and `div_act`=4. After release, the first `tick` occurs on the first enabled edge.
